// File: rtl/octave_decimator.sv
// Halves a raster 8-bit pixel stream in both dimensions, using either a rounded 2x2 box
// average or the top-left pixel of each 2x2 block, with frame/line markers on the output.
module octave_decimator #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned AVG    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] din,
  input  logic       sof_in,
  output logic [7:0] dout,
  output logic       valid_out,
  output logic       sof_out,
  output logic       eol_out,
  output logic       eof_out,
  output logic       frame_err
);

  localparam int unsigned HALF_W = WIDTH / 2;
  localparam int unsigned COL_W  = $clog2(WIDTH);
  localparam int unsigned ROW_W  = $clog2(HEIGHT);
  localparam int unsigned OCOL_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [OCOL_W-1:0]   ocol;
  logic [7:0]          hold;
  logic [8:0]          linebuf [HALF_W];

  logic                restart;
  logic                accept;
  logic [COL_W-1:0]    cur_col;
  logic [ROW_W-1:0]    cur_row;
  logic [OCOL_W-1:0]   ocol_cur;
  logic                last_col;
  logic                last_row;

  logic                fire_c;
  logic                sof_c;
  logic                eol_c;
  logic                eof_c;
  logic                ferr_c;

  logic [OCOL_W-1:0]   lb_idx;
  logic [8:0]          pair;
  logic [9:0]          quad;
  logic [9:0]          rounded;
  logic [7:0]          pix_c;

  // A sof_in beat is always pixel (0,0), whatever the counters currently hold.
  always_comb begin
    restart  = valid_in & sof_in;
    accept   = valid_in & (sof_in | (state == RUN));
    cur_col  = restart ? '0 : col;
    cur_row  = restart ? '0 : row;
    ocol_cur = restart ? '0 : ocol;
    last_col = (cur_col == COL_W'(WIDTH - 1));
    last_row = (cur_row == ROW_W'(HEIGHT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (restart) state_nxt = RUN;
      RUN:      if (accept && last_col && last_row) state_nxt = WAIT_SOF;
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    fire_c = 1'b0;
    sof_c  = 1'b0;
    eol_c  = 1'b0;
    eof_c  = 1'b0;
    ferr_c = restart && (state == RUN) && ((col != '0) || (row != '0));
    if (accept) begin
      if (AVG != 0) fire_c = cur_row[0] & cur_col[0];
      else          fire_c = ~cur_row[0] & ~cur_col[0];
    end
    if (fire_c) begin
      sof_c = ((cur_row >> 1) == '0) && (ocol_cur == '0);
      eol_c = (ocol_cur == OCOL_W'(HALF_W - 1));
      eof_c = eol_c && ((cur_row >> 1) == ROW_W'(HEIGHT / 2 - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      ocol <= '0;
      hold <= '0;
    end else begin
      if (accept) begin
        col <= last_col ? '0 : cur_col + COL_W'(1);
        if (last_col) row <= last_row ? '0 : cur_row + ROW_W'(1);
        else          row <= cur_row;
        if (!cur_col[0]) hold <= din;
      end
      if (fire_c)       ocol <= eol_c ? '0 : ocol_cur + OCOL_W'(1);
      else if (restart) ocol <= '0;
    end
  end

  // Pair sums from even rows wait in the line buffer for the matching odd-row pair.
  always_comb begin
    lb_idx  = OCOL_W'(cur_col >> 1);
    pair    = {1'b0, hold} + {1'b0, din};
    quad    = {1'b0, linebuf[lb_idx]} + {1'b0, pair};
    rounded = quad + 10'd2;
    pix_c   = (AVG != 0) ? rounded[9:2] : din;
  end

  always_ff @(posedge clk) begin
    if ((AVG != 0) && accept && !cur_row[0] && cur_col[0]) linebuf[lb_idx] <= pair;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      dout      <= '0;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      valid_out <= fire_c;
      frame_err <= ferr_c;
      if (fire_c) begin
        dout    <= pix_c;
        sof_out <= sof_c;
        eol_out <= eol_c;
        eof_out <= eof_c;
      end
    end
  end

endmodule

// File: tb/tb_octave_decimator.sv
// Directed bench: 4x4 ramp frames through average and pick instances, plus a 10x2 rounding frame.
module tb_octave_decimator;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] din;
  logic       sof;
  logic       rv;
  logic [7:0] rd;
  logic       rs;

  logic [7:0] a_dout, p_dout, r_dout;
  logic       a_valid, a_sof, a_eol, a_eof, a_ferr;
  logic       p_valid, p_sof, p_eol, p_eof, p_ferr;
  logic       r_valid, r_sof, r_eol, r_eof, r_ferr;

  int n_vec = 0;
  int n_err = 0;
  int last_avg = 0;
  int last_pick = 0;
  int avg_exp[4]  = '{6, 8, 26, 28};
  int pick_exp[4] = '{0, 2, 20, 22};
  int rnd_row0[10] = '{255, 255, 0, 0, 0, 0, 0, 1, 1, 1};
  int rnd_row1[10] = '{255, 255, 0, 1, 1, 1, 1, 1, 1, 1};
  int rnd_exp[5]   = '{255, 0, 1, 1, 1};

  always #5 clk = ~clk;

  octave_decimator #(.WIDTH(4), .HEIGHT(4), .AVG(1)) u_avg (
    .clk(clk), .rst(rst), .valid_in(valid), .din(din), .sof_in(sof),
    .dout(a_dout), .valid_out(a_valid), .sof_out(a_sof), .eol_out(a_eol),
    .eof_out(a_eof), .frame_err(a_ferr)
  );

  octave_decimator #(.WIDTH(4), .HEIGHT(4), .AVG(0)) u_pick (
    .clk(clk), .rst(rst), .valid_in(valid), .din(din), .sof_in(sof),
    .dout(p_dout), .valid_out(p_valid), .sof_out(p_sof), .eol_out(p_eol),
    .eof_out(p_eof), .frame_err(p_ferr)
  );

  octave_decimator #(.WIDTH(10), .HEIGHT(2), .AVG(1)) u_rnd (
    .clk(clk), .rst(rst), .valid_in(rv), .din(rd), .sof_in(rs),
    .dout(r_dout), .valid_out(r_valid), .sof_out(r_sof), .eol_out(r_eol),
    .eof_out(r_eof), .frame_err(r_ferr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One ramp beat at logical position (r,c); checks the registered response one cycle later.
  task automatic pix(input int r, input int c, input bit s, input bit ferr);
    int  k;
    bit  fa;
    bit  fp;
    valid = 1'b1;
    din   = 8'(10 * r + c);
    sof   = s;
    @(posedge clk); #1;
    valid = 1'b0;
    sof   = 1'b0;
    k  = (r / 2) * 2 + c / 2;
    fa = (r % 2 == 1) && (c % 2 == 1);
    fp = (r % 2 == 0) && (c % 2 == 0);
    chk($sformatf("avg valid r%0d c%0d", r, c), 32'(a_valid), 32'(fa));
    chk($sformatf("pick valid r%0d c%0d", r, c), 32'(p_valid), 32'(fp));
    chk($sformatf("avg ferr r%0d c%0d", r, c), 32'(a_ferr), 32'(ferr));
    chk($sformatf("pick ferr r%0d c%0d", r, c), 32'(p_ferr), 32'(ferr));
    if (fa) begin
      chk($sformatf("avg dout k%0d", k), 32'(a_dout), 32'(avg_exp[k]));
      chk($sformatf("avg sof k%0d", k), 32'(a_sof), 32'(k == 0));
      chk($sformatf("avg eol k%0d", k), 32'(a_eol), 32'(c / 2 == 1));
      chk($sformatf("avg eof k%0d", k), 32'(a_eof), 32'(k == 3));
      last_avg = avg_exp[k];
    end
    if (fp) begin
      chk($sformatf("pick dout k%0d", k), 32'(p_dout), 32'(pick_exp[k]));
      chk($sformatf("pick sof k%0d", k), 32'(p_sof), 32'(k == 0));
      chk($sformatf("pick eol k%0d", k), 32'(p_eol), 32'(c / 2 == 1));
      chk($sformatf("pick eof k%0d", k), 32'(p_eof), 32'(k == 3));
      last_pick = pick_exp[k];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle avg valid", 32'(a_valid), 32'd0);
      chk("idle pick valid", 32'(p_valid), 32'd0);
      chk("idle avg dout held", 32'(a_dout), 32'(last_avg));
      chk("idle pick dout held", 32'(p_dout), 32'(last_pick));
    end
  endtask

  task automatic ramp_frame(input int gap_max, input bit first_err);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix(r, c, (r == 0) && (c == 0), first_err && (r == 0) && (c == 0));
        if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
      end
    end
  endtask

  task automatic rnd_frame();
    int k;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 10; c++) begin
        rv = 1'b1;
        rd = 8'((r == 0) ? rnd_row0[c] : rnd_row1[c]);
        rs = (r == 0) && (c == 0);
        @(posedge clk); #1;
        rv = 1'b0;
        rs = 1'b0;
        k  = c / 2;
        chk($sformatf("rnd valid r%0d c%0d", r, c), 32'(r_valid), 32'((r == 1) && (c % 2 == 1)));
        if ((r == 1) && (c % 2 == 1)) begin
          chk($sformatf("rnd dout k%0d", k), 32'(r_dout), 32'(rnd_exp[k]));
          chk($sformatf("rnd sof k%0d", k), 32'(r_sof), 32'(k == 0));
          chk($sformatf("rnd eol k%0d", k), 32'(r_eol), 32'(k == 4));
          chk($sformatf("rnd eof k%0d", k), 32'(r_eof), 32'(k == 4));
        end
      end
    end
    chk("rnd ferr", 32'(r_ferr), 32'd0);
  endtask

  task automatic check_cleared(input string who, input logic [7:0] d, input logic v,
                               input logic s, input logic l, input logic e, input logic f);
    chk({who, " valid"}, 32'(v), 32'd0);
    chk({who, " dout"}, 32'(d), 32'd0);
    chk({who, " sof"}, 32'(s), 32'd0);
    chk({who, " eol"}, 32'(l), 32'd0);
    chk({who, " eof"}, 32'(e), 32'd0);
    chk({who, " ferr"}, 32'(f), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; din = '0; sof = 1'b0;
    rv = 1'b0; rd = '0; rs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset avg", a_dout, a_valid, a_sof, a_eol, a_eof, a_ferr);
    check_cleared("reset pick", p_dout, p_valid, p_sof, p_eol, p_eof, p_ferr);
    rst = 1'b0;
    idle(2);

    ramp_frame(0, 1'b0);
    idle(3);

    rnd_frame();
    idle(2);

    for (int f = 0; f < 3; f++) ramp_frame(5, 1'b0);
    idle(2);

    // Aborted frame: sof_in at (1,2) restarts, and that beat is pixel (0,0) of a full frame.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ((r == 1) && (c == 2)) break;
        pix(r, c, (r == 0) && (c == 0), 1'b0);
      end
    end
    ramp_frame(0, 1'b1);
    idle(2);

    // Reset mid-frame at (2,1), then stray beats without sof_in.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ((r == 2) && (c == 1)) break;
        pix(r, c, (r == 0) && (c == 0), 1'b0);
      end
    end
    valid = 1'b1; din = 8'd21; sof = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    check_cleared("midrst avg", a_dout, a_valid, a_sof, a_eol, a_eof, a_ferr);
    check_cleared("midrst pick", p_dout, p_valid, p_sof, p_eol, p_eof, p_ferr);
    last_avg = 0;
    last_pick = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1;
      din   = 8'(22 + i);
      @(posedge clk); #1;
      valid = 1'b0;
      chk($sformatf("stray avg valid %0d", i), 32'(a_valid), 32'd0);
      chk($sformatf("stray pick valid %0d", i), 32'(p_valid), 32'd0);
    end
    idle(1);
    ramp_frame(0, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/octave_decimator.md
Name: octave_decimator

Overview:
- Downstream consumer of the upsampler's pixel stream in the SIFT pyramid path.
- Takes a raster-order 8-bit pixel stream and produces the next-octave image at half width and half height.
- In average mode, each output pixel is the rounded mean of its 2x2 input block.
- Runs without backpressure: input is valid-qualified only, and the output is a valid-qualified stream with frame/line markers for the Gaussian/DoG stages.

Parameters:
- WIDTH, 640, input image width in pixels; even, >= 2.
- HEIGHT, 480, input image height in lines; even, >= 2.
- AVG, 1, 1 = 2x2 box average; 0 = pick the top-left pixel of each 2x2 block.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  input pixel beat qualifier
- din  in  8  input pixel
- sof_in  in  1  marks the first pixel (row 0, col 0) of a frame; sampled only when valid_in=1
- dout  out  8  decimated pixel
- valid_out  out  1  output beat qualifier
- sof_out  out  1  first output pixel of frame, qualified by valid_out
- eol_out  out  1  last output pixel of an output line, qualified by valid_out
- eof_out  out  1  last output pixel of frame, qualified by valid_out
- frame_err  out  1  one-cycle pulse when sof_in arrives mid-frame

Behaviour:
- Reset:
  - State goes to WAIT_SOF; col, row, output-column and hold register clear to 0.
  - All outputs are 0.
  - Line buffer contents are not reset; they are always written before being read.
- States:
  - WAIT_SOF: beats with sof_in=0 are dropped, with no counter change. A beat with sof_in=1 is processed as pixel (0,0), and the state goes to RUN.
  - RUN: each valid_in beat is processed at the current (row, col), then col increments. At col=WIDTH-1, col wraps to 0 and row increments. At the last pixel (row=HEIGHT-1, col=WIDTH-1), the state returns to WAIT_SOF.
  - RUN, sof_in=1 at any position other than (0,0): frame_err pulses for 1 cycle, counters restart, and that beat is processed as (0,0).
- valid_in=0 cycles: counters, state and hold register keep their values, and valid_out=0. Gaps of any length are legal.
- Datapath for AVG=1:
  - Even col: din goes to the 8-bit hold register.
  - Odd col: pair sum p = hold + din, 9 bits.
  - Even row, odd col: linebuf[col>>1] <= p. The line buffer is WIDTH/2 entries x 9 bits.
  - Odd row, odd col: t = linebuf[col>>1] + p (10 bits), and the output is (t + 2) >> 2. The result is always <= 255, so no saturation.
  - Output fires on odd row, odd col beats.
- Datapath for AVG=0: output = din on even row, even col beats. The hold register and line buffer are unused.
- Output timing:
  - Outputs are registered. valid_out is high exactly 1 cycle after the triggering input beat, for 1 cycle.
  - dout and the flags are held until the next output beat.
- Output markers:
  - The output-column counter runs 0..WIDTH/2-1.
  - sof_out on the first output of a frame.
  - eol_out when output col = WIDTH/2-1.
  - eof_out on the final output, together with eol_out.
- Output count is exactly (WIDTH/2)*(HEIGHT/2) per complete frame.
- An aborted frame (restarted by sof_in, or by rst) produces no eof_out.
- Line buffer: one access per cycle (a write on even rows, a read on odd rows). Asynchronous read is permitted.
- Reset mid-frame: any output beat already registered is cleared. Input is dropped until the next sof_in.

Test Plan:
- Ramp frame, AVG=1, WIDTH=4, HEIGHT=4, din=10*row+col, no gaps -> dout 6,8,26,28.
  - sof_out on 6; eol_out on 8 and 28; eof_out on 28.
  - Each output 1 cycle after the odd/odd beat; no other valid_out.
- Rounding, AVG=1, 2x2 blocks {255,255,255,255} -> 255; {0,0,0,1} -> 0; {0,0,1,1} -> 1; {0,1,1,1} -> 1; {1,1,1,1} -> 1.
- Same ramp as the first scenario with AVG=0 -> dout 0,2,20,22, each 1 cycle after its even/even beat; same flag placement as the first scenario.
- Same ramp as the first scenario with random 0-5 cycle valid_in gaps, 3 consecutive frames -> identical output sequence and flags per frame.
- sof_in at (row1, col2) mid-frame -> frame_err high exactly 1 cycle; no eof_out for the aborted frame.
  - The following complete frame yields 6,8,26,28 correctly.
- rst asserted at (row2, col1), then 20 ramp beats without sof_in -> valid_out stays 0.
  - The next sof_in frame yields 6,8,26,28.
